// File: rtl/xor_parity_accumulator.sv
// Multi-lane XOR/parity engine: per-word XOR or whole-frame running XOR, with
// valid/ready handshakes on both sides and a saturating frame beat counter.

module xpa_lane #(
    parameter int WIDTH = 8
) (
    input  logic             first_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] z_o,
    output logic             p_o
);
    // A frame's first beat starts from zero, so stale accumulator contents never leak in.
    assign z_o = (first_i ? '0 : acc_i) ^ data_i;
    assign p_o = ^z_o;
endmodule

module xor_parity_accumulator #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   RN,
    input  logic                   MODE,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [LANES*WIDTH-1:0] IN_DATA,
    input  logic                   IN_LAST,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [LANES*WIDTH-1:0] OUT_Z,
    output logic [LANES-1:0]       OUT_P,
    output logic [CNT_W-1:0]       OUT_CNT,
    output logic                   OUT_OVF
);
    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                        state_q, state_d;
    logic [LANES-1:0][WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          ovf_q, ovf_d;
    logic                          mode_q, mode_d;
    logic [LANES-1:0][WIDTH-1:0]   out_z_q, out_z_d;
    logic [LANES-1:0]              out_p_q, out_p_d;
    logic [CNT_W-1:0]              out_cnt_q, out_cnt_d;
    logic                          out_ovf_q, out_ovf_d;
    logic                          out_vld_q, out_vld_d;

    logic [LANES-1:0][WIDTH-1:0]   data_w, z_next;
    logic [LANES-1:0]              p_next;
    logic                          fire, first, mode_eff;
    logic [CNT_W-1:0]              cnt_base, cnt_inc;
    logic                          cnt_sat, ovf_inc;

    assign data_w   = IN_DATA;
    assign IN_READY = (state_q == HOLD) ? OUT_READY : 1'b1;
    assign fire     = IN_VALID & IN_READY;
    assign first    = (state_q != ACC);
    assign mode_eff = first ? MODE : mode_q;

    assign cnt_base = first ? '0 : cnt_q;
    assign cnt_sat  = (cnt_base == CNT_MAX);
    assign cnt_inc  = cnt_sat ? cnt_base : cnt_base + CNT_ONE;
    assign ovf_inc  = (first ? 1'b0 : ovf_q) | cnt_sat;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        xpa_lane #(.WIDTH(WIDTH)) u_lane (
            .first_i (first),
            .acc_i   (acc_q[k]),
            .data_i  (data_w[k]),
            .z_o     (z_next[k]),
            .p_o     (p_next[k])
        );
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        mode_d    = mode_q;
        out_z_d   = out_z_q;
        out_p_d   = out_p_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;
        out_vld_d = out_vld_q;
        if (fire) begin
            if (first) mode_d = MODE;
            if (!mode_eff || IN_LAST) begin
                out_z_d   = z_next;
                out_p_d   = p_next;
                out_cnt_d = cnt_inc;
                out_ovf_d = ovf_inc;
                out_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
                state_d   = HOLD;
            end else begin
                // Any held result was consumed on this same edge (fire implies OUT_READY in HOLD).
                acc_d     = z_next;
                cnt_d     = cnt_inc;
                ovf_d     = ovf_inc;
                out_vld_d = 1'b0;
                state_d   = ACC;
            end
        end else if (state_q == HOLD && OUT_READY) begin
            out_vld_d = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            mode_q    <= 1'b0;
            out_z_q   <= '0;
            out_p_q   <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            mode_q    <= mode_d;
            out_z_q   <= out_z_d;
            out_p_q   <= out_p_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign OUT_VALID = out_vld_q;
    assign OUT_Z     = out_z_q;
    assign OUT_P     = out_p_q;
    assign OUT_CNT   = out_cnt_q;
    assign OUT_OVF   = out_ovf_q;
endmodule
